// File: rtl/prefetch_pkg.sv
// Shared types for the prefetch queue: queue entry layout, drain FSM states and PC step.
package prefetch_pkg;

  localparam int PFQ_XLEN    = 32;
  localparam int PFQ_ILEN    = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [PFQ_ILEN-1:0] instr;
    logic [PFQ_XLEN-1:0] pc;
  } pfq_entry_t;

  typedef enum logic [0:0] {
    PFQ_RUN   = 1'b0,
    PFQ_DRAIN = 1'b1
  } pfq_state_e;

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic logic [PFQ_XLEN-1:0] pc_next(input logic [PFQ_XLEN-1:0] pc);
    return pc + PFQ_XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Registered DEPTH-entry FIFO of pfq_entry_t with synchronous clear; head is read
// straight from storage so it follows a push by one cycle.
module pfq_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  pfq_entry_t               data_i,
  output pfq_entry_t               head_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  pfq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push_i && !clear_i;
  assign do_pop_s  = pop_i && !clear_i && (occ_q != {OCC_W{1'b0}});

  // Storage, pointers and occupancy; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/prefetch_queue_unit.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited IMEM requests and
// buffers in-order responses. Defining PFB_PERF_CNT_EN adds flush/starvation counters.
module prefetch_queue_unit
  import prefetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = PFQ_XLEN,
  parameter int              ILEN     = PFQ_ILEN,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
`ifdef PFB_PERF_CNT_EN
  ,
  output logic [31:0]     perf_flush_cnt_o,
  output logic [31:0]     perf_starve_cnt_o
`endif
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = OCC_W + 1;

  pfq_state_e       state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [OCC_W-1:0] out_q, out_d;
  logic [OCC_W-1:0] discard_q, discard_d;
  logic [OCC_W-1:0] occ_s;
  logic [SUM_W-1:0] occ_sum_s;
  logic             credit_ok_s;
  logic             accept_s;
  logic             rsp_s;
  logic             push_s;
  logic             pop_s;
  pfq_entry_t       push_entry_s;
  pfq_entry_t       head_s;

  // Outstanding count includes requests still to be discarded, so credit can never overbook the queue.
  assign occ_sum_s   = SUM_W'(occ_s) + SUM_W'(out_q);
  assign credit_ok_s = (occ_sum_s < SUM_W'(DEPTH)) && (out_q < OCC_W'(MAX_OUT));
  assign imem_req_o  = !rst_i && !flush_i && credit_ok_s;
  assign imem_addr_o = fetch_pc_q;
  // A grant coinciding with a flush is still counted so its response gets dropped.
  assign accept_s    = imem_gnt_i && credit_ok_s;
  assign rsp_s       = imem_rvalid_i && (out_q != {OCC_W{1'b0}});
  assign push_s      = rsp_s && (state_q == PFQ_RUN) && !flush_i;
  assign pop_s       = instr_valid_o && instr_ready_i && !flush_i;

  assign push_entry_s.instr = imem_rdata_i;
  assign push_entry_s.pc    = resp_pc_q;

  pfq_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_entry_s),
    .head_o  (head_s),
    .occ_o   (occ_s)
  );

  assign instr_valid_o = (occ_s != {OCC_W{1'b0}});
  assign instr_o       = head_s.instr;
  assign instr_pc_o    = head_s.pc;

  // Next-state for fetch/response PCs, outstanding/discard counters and the drain FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    out_d      = out_q + OCC_W'(accept_s) - OCC_W'(rsp_s);
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
      resp_pc_d  = flush_pc_i;
      discard_d  = out_d;
      state_d    = (out_d != {OCC_W{1'b0}}) ? PFQ_DRAIN : PFQ_RUN;
    end else begin
      if (accept_s) begin
        fetch_pc_d = pc_next(fetch_pc_q);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      case (state_q)
        PFQ_RUN: begin
          if (rsp_s) begin
            resp_pc_d = pc_next(resp_pc_q);
          end else begin
            resp_pc_d = resp_pc_q;
          end
        end
        PFQ_DRAIN: begin
          if (rsp_s) begin
            discard_d = discard_q - OCC_W'(1);
            state_d   = (discard_q == OCC_W'(1)) ? PFQ_RUN : PFQ_DRAIN;
          end else begin
            discard_d = discard_q;
          end
        end
        default: state_d = PFQ_RUN;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= PFQ_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= {OCC_W{1'b0}};
      discard_q  <= {OCC_W{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
    end
  end

`ifdef PFB_PERF_CNT_EN
  logic [31:0] flush_cnt_q;
  logic [31:0] starve_cnt_q;

  // Wrapping performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q  <= 32'd0;
      starve_cnt_q <= 32'd0;
    end else begin
      flush_cnt_q  <= flush_cnt_q + {31'd0, flush_i};
      starve_cnt_q <= starve_cnt_q + {31'd0, (instr_ready_i && !instr_valid_o)};
    end
  end

  assign perf_flush_cnt_o  = flush_cnt_q;
  assign perf_starve_cnt_o = starve_cnt_q;
`endif

endmodule
